// File: rtl/wdata_handler.sv
// rtl/wdata_handler.sv - deskews systolic-array result columns and writes full rows to RAM port C
//
// Purpose:
//    Takes the skewed C results leaving the systolic array, realigns the
//    columns into complete rows and writes each row to consecutive RAM
//    addresses starting at a latched base. A start/done handshake frames
//    one result matrix of a latched number of rows.
//
// Ports:
//    clk_i        clock, all logic on the rising edge
//    rst_i        synchronous active-high reset
//    start_i      begin a job (accepted only in IDLE)
//    base_addr_i  first row address, latched on an accepted start
//    num_rows_i   rows to write, latched on an accepted start
//    col_valid_i  per-column result valid (skewed, column j lags column 0 by j)
//    col_data_i   per-column result data, lane j at [j*DATA_W +: DATA_W]
//    busy_o       high while collecting rows
//    done_o       one-cycle pulse at job end
//    err_o        sticky skew error, cleared on an accepted start
//    addr_c_o     RAM port C row address
//    wdata_c_o    RAM port C row data, lanes in column order
//    we_c_o       RAM port C write enable

module wdata_handler #(
   parameter int N      = 4,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_W-1:0]     base_addr_i,
   input  logic [ADDR_W-1:0]     num_rows_i,
   input  logic [N-1:0]          col_valid_i,
   input  logic [N*DATA_W-1:0]   col_data_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [ADDR_W-1:0]     addr_c_o,
   output logic [N*DATA_W-1:0]   wdata_c_o,
   output logic                  we_c_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [ADDR_W-1:0]     r_base;
   logic [ADDR_W-1:0]     r_num_rows;
   logic [ADDR_W-1:0]     r_row_cnt;
   logic                  r_err;
   logic                  r_we;
   logic [ADDR_W-1:0]     r_addr;
   logic [N*DATA_W-1:0]   r_wdata;

   logic [N-1:0]          w_dv;
   logic [N*DATA_W-1:0]   w_dd;
   logic                  w_row_valid;
   logic                  w_partial;
   logic [ADDR_W-1:0]     w_cnt_inc;
   logic                  w_busy;
   logic                  w_done;

   // Column j lags column 0 by j cycles, so it is delayed by N-1-j stages to
   // line every column up with the last one. The lines shift in every state.
   for (genvar j = 0; j < N; j++) begin : g_col
      if (j == N - 1) begin : g_direct
         assign w_dv[j]                   = col_valid_i[j];
         assign w_dd[j*DATA_W +: DATA_W]  = col_data_i[j*DATA_W +: DATA_W];
      end else begin : g_dly
         localparam int DEPTH = N - 1 - j;
         logic [DEPTH-1:0]        r_v;
         logic [DEPTH*DATA_W-1:0] r_d;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_v <= '0;
               r_d <= '0;
            end else begin
               r_v[0]          <= col_valid_i[j];
               r_d[0 +: DATA_W] <= col_data_i[j*DATA_W +: DATA_W];
               for (int k = 1; k < DEPTH; k++) begin
                  r_v[k]                <= r_v[k-1];
                  r_d[k*DATA_W +: DATA_W] <= r_d[(k-1)*DATA_W +: DATA_W];
               end
            end
         end

         assign w_dv[j]                  = r_v[DEPTH-1];
         assign w_dd[j*DATA_W +: DATA_W] = r_d[(DEPTH-1)*DATA_W +: DATA_W];
      end
   end

   assign w_row_valid = &w_dv;
   // Some but not all columns present: the slice is misaligned and dropped.
   assign w_partial   = (|w_dv) & ~w_row_valid;
   assign w_cnt_inc   = r_row_cnt + ADDR_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt = (num_rows_i == '0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            w_busy = 1'b1;
            if (w_row_valid && (w_cnt_inc == r_num_rows)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_base     <= '0;
         r_num_rows <= '0;
         r_row_cnt  <= '0;
         r_err      <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_base     <= base_addr_i;
                  r_num_rows <= num_rows_i;
                  r_row_cnt  <= '0;
                  r_err      <= 1'b0;
               end
            end
            S_COLLECT: begin
               if (w_row_valid) begin
                  r_we      <= 1'b1;
                  // Address wraps modulo 2^ADDR_W by construction.
                  r_addr    <= r_base + r_row_cnt;
                  r_wdata   <= w_dd;
                  r_row_cnt <= w_cnt_inc;
               end
               if (w_partial) begin
                  r_err <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy_o    = w_busy;
   assign done_o    = w_done;
   assign err_o     = r_err;
   assign we_c_o    = r_we;
   assign addr_c_o  = r_addr;
   assign wdata_c_o = r_wdata;

endmodule

// File: tb/tb_wdata_handler.sv
// tb/tb_wdata_handler.sv - self-checking bench for wdata_handler with a row-level reference model

module tb_wdata_handler;

   localparam int N    = 4;
   localparam int DW   = 16;
   localparam int AW   = 4;
   localparam int LEN  = 32;
   localparam int NONE = 1000;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              start_i;
   logic [AW-1:0]     base_addr_i;
   logic [AW-1:0]     num_rows_i;
   logic [N-1:0]      col_valid_i;
   logic [N*DW-1:0]   col_data_i;
   logic              busy_o;
   logic              done_o;
   logic              err_o;
   logic [AW-1:0]     addr_c_o;
   logic [N*DW-1:0]   wdata_c_o;
   logic              we_c_o;

   wdata_handler #(.N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .num_rows_i  (num_rows_i),
      .col_valid_i (col_valid_i),
      .col_data_i  (col_data_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .addr_c_o    (addr_c_o),
      .wdata_c_o   (wdata_c_o),
      .we_c_o      (we_c_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // per-cycle column schedule for one scenario
   logic [N-1:0]    sched_v [0:63];
   logic [N*DW-1:0] sched_d [0:63];
   int              row_t[$];
   int              row_late[$];
   int              row_x[$];
   logic [63:0]     row_d[$];

   // observed activity, relative to scenario start
   bit          mon_en = 1'b0;
   int          t_base = 0;
   int          obs_cyc[$];
   logic [63:0] obs_addr[$];
   logic [63:0] obs_data[$];
   int          obs_done[$];
   int          obs_busy = 0;

   // expected activity from the model
   int          exp_cyc[$];
   logic [63:0] exp_addr[$];
   logic [63:0] exp_data[$];
   int          exp_done_cyc;
   int          exp_done_n;
   int          exp_busy;
   logic        exp_err;

   always @(negedge clk) begin
      if (mon_en) begin
         if (we_c_o) begin
            obs_cyc.push_back(cyc - t_base);
            obs_addr.push_back(64'(addr_c_o));
            obs_data.push_back(64'(wdata_c_o));
         end
         if (done_o) obs_done.push_back(cyc - t_base);
         if (busy_o) obs_busy = obs_busy + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sched();
      for (int i = 0; i < 64; i++) begin
         sched_v[i] = '0;
         sched_d[i] = '0;
      end
      row_t.delete(); row_late.delete(); row_x.delete(); row_d.delete();
   endtask

   // late >= 0 delays that column by 'extra' cycles, breaking the skew
   task automatic add_row(input int t, input int late, input int extra, input logic [63:0] d);
      row_t.push_back(t); row_late.push_back(late); row_x.push_back(extra); row_d.push_back(d);
      for (int j = 0; j < N; j++) begin
         int c;
         c = t + j + ((j == late) ? extra : 0);
         sched_v[c][j] = 1'b1;
         sched_d[c][j*DW +: DW] = d[j*DW +: DW];
      end
   endtask

   function automatic logic [63:0] rand_row();
      return {$urandom, $urandom};
   endfunction

   // Row-level model: a correctly skewed row whose column 0 arrives at t is
   // complete at t+N-1 and written at t+N if the job is collecting and still
   // short of its count; misaligned rows only raise the error while collecting.
   task automatic model(input int s, input int base, input int count, input int rc);
      int written;
      int cend;
      int bend;
      written = 0;
      cend    = -1;
      exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
      exp_err = 1'b0;
      exp_done_n = 0;
      exp_done_cyc = -1;
      if (count == 0) begin
         exp_done_n   = 1;
         exp_done_cyc = s + 1;
         exp_busy     = 0;
      end else begin
         for (int i = 0; i < row_t.size(); i++) begin
            if (row_late[i] < 0) begin
               int a;
               a = row_t[i] + N - 1;
               if (a > s && a < rc && written < count) begin
                  exp_cyc.push_back(a + 1);
                  exp_addr.push_back(64'((base + written) % (1 << AW)));
                  exp_data.push_back(row_d[i]);
                  written++;
                  if (written == count) cend = a;
               end
            end
         end
         for (int i = 0; i < row_t.size(); i++) begin
            if (row_late[i] >= 0) begin
               for (int j = 0; j < N; j++) begin
                  int p;
                  p = row_t[i] + j + ((j == row_late[i]) ? row_x[i] : 0) + (N - 1 - j);
                  if (p > s && (cend < 0 || p <= cend) && p < rc) exp_err = 1'b1;
               end
            end
         end
         if (cend >= 0 && cend < rc) begin
            exp_done_n   = 1;
            exp_done_cyc = cend + 1;
         end
         bend = (cend >= 0) ? cend : ((rc < NONE) ? rc : LEN - 1);
         if (rc < bend) bend = rc;
         exp_busy = bend - s;
      end
      if (rc < NONE) exp_err = 1'b0;
   endtask

   task automatic run_scn(input int s, input int s2, input int rc, input int base, input int count);
      obs_cyc.delete(); obs_addr.delete(); obs_data.delete(); obs_done.delete();
      obs_busy = 0;
      t_base   = cyc;
      mon_en   = 1'b1;
      for (int i = 0; i < LEN; i++) begin
         col_valid_i = sched_v[i];
         col_data_i  = sched_d[i];
         start_i     = (i == s) || (i == s2);
         rst_i       = (i == rc);
         if (i == s) begin
            base_addr_i = AW'(base);
            num_rows_i  = AW'(count);
         end else begin
            base_addr_i = AW'($urandom);
            num_rows_i  = AW'($urandom);
         end
         tick();
      end
      mon_en      = 1'b0;
      start_i     = 1'b0;
      rst_i       = 1'b0;
      col_valid_i = '0;
      col_data_i  = '0;
   endtask

   task automatic check_scn(input string name);
      int n;
      check($sformatf("%s n_writes", name), 64'(obs_cyc.size()), 64'(exp_cyc.size()));
      n = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s w%0d cycle", name, i), 64'(obs_cyc[i]), 64'(exp_cyc[i]));
         check($sformatf("%s w%0d addr", name, i), obs_addr[i], exp_addr[i]);
         check($sformatf("%s w%0d data", name, i), obs_data[i], exp_data[i]);
      end
      check($sformatf("%s n_done", name), 64'(obs_done.size()), 64'(exp_done_n));
      if (obs_done.size() > 0 && exp_done_n > 0)
         check($sformatf("%s done cycle", name), 64'(obs_done[0]), 64'(exp_done_cyc));
      check($sformatf("%s busy cycles", name), 64'(obs_busy), 64'(exp_busy));
      check($sformatf("%s err", name), 64'(err_o), 64'(exp_err));
   endtask

   initial begin
      logic [63:0] d;
      rst_i       = 1'b1;
      start_i     = 1'b0;
      base_addr_i = '0;
      num_rows_i  = '0;
      col_valid_i = '0;
      col_data_i  = '0;
      tick(); tick(); tick();
      check("reset busy",  64'(busy_o),    64'd0);
      check("reset done",  64'(done_o),    64'd0);
      check("reset err",   64'(err_o),     64'd0);
      check("reset we",    64'(we_c_o),    64'd0);
      check("reset addr",  64'(addr_c_o),  64'd0);
      check("reset wdata", 64'(wdata_c_o), 64'd0);
      rst_i = 1'b0;
      tick();

      // three back-to-back rows, data 100*r+j
      clear_sched();
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < N; j++) d[j*DW +: DW] = DW'(100 * r + j);
         add_row(2 + r, -1, 0, d);
      end
      model(0, 10, 3, NONE);
      run_scn(0, NONE, NONE, 10, 3);
      check_scn("basic");

      // address wrap
      clear_sched();
      add_row(1, -1, 0, rand_row());
      add_row(2, -1, 0, rand_row());
      model(0, (1 << AW) - 1, 2, NONE);
      run_scn(0, NONE, NONE, (1 << AW) - 1, 2);
      check_scn("wrap");

      // column 2 one cycle late
      clear_sched();
      add_row(2, 2, 1, rand_row());
      add_row(8, -1, 0, rand_row());
      add_row(9, -1, 0, rand_row());
      model(0, 1, 2, NONE);
      run_scn(0, NONE, NONE, 1, 2);
      check_scn("skew_err");

      // zero rows; start also clears the sticky error
      clear_sched();
      model(1, 7, 0, NONE);
      run_scn(1, NONE, NONE, 7, 0);
      check_scn("zero_rows");

      // five rows, count 2, extra start while collecting
      clear_sched();
      for (int r = 0; r < 5; r++) add_row(2 + r, -1, 0, rand_row());
      model(0, 5, 2, NONE);
      run_scn(0, 3, NONE, 5, 2);
      check_scn("overflow");

      // reset after the first write
      clear_sched();
      for (int r = 0; r < 3; r++) add_row(2 + r, -1, 0, rand_row());
      model(0, 0, 3, 6);
      run_scn(0, NONE, 6, 0, 3);
      check_scn("mid_reset");
      check("mid_reset addr",  64'(addr_c_o),  64'd0);
      check("mid_reset wdata", 64'(wdata_c_o), 64'd0);

      // randomized jobs, some with rows already in flight at start
      for (int k = 0; k < 6; k++) begin
         int count, nrows, s, t, base;
         clear_sched();
         count = $urandom_range(1, 4);
         nrows = count + $urandom_range(1, 3);
         s     = $urandom_range(0, 3);
         base  = $urandom_range(0, (1 << AW) - 1);
         t     = $urandom_range(0, 4);
         for (int r = 0; r < nrows; r++) begin
            add_row(t, -1, 0, rand_row());
            t = t + 1 + $urandom_range(0, 1);
         end
         model(s, base, count, NONE);
         run_scn(s, NONE, NONE, base, count);
         check_scn($sformatf("rand%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wdata_handler.md
Name: wdata_handler

Overview:
- Write-back block for the matrix-multiplication accelerator, the counterpart of rdata_handler.
- rdata_handler fetches A/B rows from the dualport_ram and skews them into the systolic array. wdata_handler takes the skewed C results leaving the array, deskews them into full rows, and writes each row to dualport_ram port C (addr_c_i / wdata_c_i / we_c_i).
- A start/done handshake with the controller frames one result matrix of num_rows rows, written to consecutive addresses from a base address.

Parameters:
N, SYS_ARRAY_SIZE, number of array columns / data_t lanes per row
ADDR_W, $bits(addr_t), width of memory row address and row counter

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  reset, synchronous, active-high
start_i  input  1  begin a write-back job; sampled only in IDLE
base_addr_i  input  addr_t  first row address; latched on accepted start
num_rows_i  input  ADDR_W  rows to write; latched on accepted start
col_valid_i  input  N  per-column result valid from array (skewed)
col_data_i  input  data_t[N]  per-column result data (skewed)
busy_o  output  1  high while in COLLECT
done_o  output  1  one-cycle pulse at job end
err_o  output  1  sticky skew error; cleared on accepted start
addr_c_o  output  addr_t  to dualport_ram addr_c_i
wdata_c_o  output  data_t[N]  to dualport_ram wdata_c_i
we_c_o  output  1  to dualport_ram we_c_i

Behaviour:
- Skew convention: column j of result row r arrives exactly j cycles after column 0 of row r.
- Deskew: each column j passes through a delay line of N-1-j register stages carrying valid and data. Column N-1 is undelayed. Delay lines shift every cycle in every state.
- Aligned row valid = AND of all N delayed valids.
- Partial alignment: if some delayed valids are set but not all, the slice is discarded. In COLLECT, err_o is set and stays high until the next accepted start.
- Reset: all state, counters, latched base and count cleared; all delay-line valids cleared. busy_o=0, done_o=0, err_o=0, we_c_o=0, addr_c_o=0, wdata_c_o=0.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE: start_i=1 latches base_addr_i and num_rows_i, clears row counter and err_o. Go to COLLECT, or to DONE if num_rows_i==0.
  - COLLECT: busy_o=1. Each cycle with aligned row valid produces a write, and the row counter increments. When the counter reaches the latched count, go to DONE.
  - DONE: done_o=1 for exactly one cycle, busy_o=0, then go to IDLE.
- Write outputs are registered. An aligned row in cycle t (in COLLECT) gives we_c_o=1 in cycle t+1, with addr_c_o=base+row_index and wdata_c_o=aligned row, lanes in column order.
- End-to-end latency: column 0 of row r arriving at cycle t is written at t+N.
- we_c_o is 0 in every cycle without a write. addr_c_o and wdata_c_o hold their last values.
- The final write occurs on the cycle the FSM is in DONE, so done_o and the last we_c_o coincide.
- Address arithmetic is modulo 2^ADDR_W: base+index wraps, no error.
- Back-to-back rows (one per cycle) are supported at full rate.
- Aligned rows arriving in IDLE or DONE, or after the count is reached, are dropped: no write, no error.
- start_i in COLLECT or DONE is ignored.
- A start accepted in IDLE with in-flight data in the delay lines: rows completing after entry to COLLECT are written.
- rst_i mid-job: back to IDLE next cycle, outputs per reset values, delay lines flushed, no further writes.

Test Plan:
- N=4, base=10, num_rows=3, three rows skewed correctly back-to-back (row r, col j = 100*r+j) -> we_c_o high 3 consecutive cycles starting 4 cycles after row 0 col 0. addr 10,11,12; data {0,1,2,3},{100..103},{200..203}. done_o coincides with addr 12. err_o=0.
- base=2^ADDR_W-1, num_rows=2 -> writes to addr 2^ADDR_W-1 then 0.
- num_rows=0 with start -> done_o pulse the cycle after start, busy_o never high, no we_c_o.
- Row with column 2 valid one cycle late (N=4) -> no write for that row, err_o=1 and held. Next start clears err_o.
- Five valid rows with num_rows=2 -> exactly 2 writes, rows 3-5 dropped. Second start_i pulsed during COLLECT has no effect.
- rst_i asserted after the first of 3 writes -> next cycle busy_o=0, we_c_o=0, no further writes even though rows 2-3 are in the delay lines.
